fetcher: RTL and testbench

//  Instruction fetch stage. Holds the PC, requests instructions from the icache, decodes control

---
 rtl/fetcher.sv | 148 ++++++++++++++
 tb/tb_fetcher.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch stage: PC, icache request, branch decode, IQ push
module fetcher #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  output logic            fet_icache_req,
  output logic [XLEN-1:0] fet_icache_addr,
  input  logic            icache_ready,
  input  logic [31:0]     icache_inst,
  output logic [XLEN-1:0] fet_inst_addr,
  input  logic            bp_pred,
  input  logic            iq_full,
  output logic            fet_iq_valid,
  output logic [31:0]     fet_iq_inst,
  output logic [XLEN-1:0] fet_iq_addr,
  output logic            fet_iq_pred_jump,
  output logic [XLEN-1:0] fet_iq_pred_addr,
  input  logic            rob_flush,
  input  logic [XLEN-1:0] rob_flush_pc
);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // FETCH issues requests; WAIT_JALR stalls until the ROB resolves the indirect target.
  typedef enum logic {
    S_FETCH     = 1'b0,
    S_WAIT_JALR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            iq_valid_q, iq_valid_d;
  logic [31:0]     iq_inst_q, iq_inst_d;
  logic [XLEN-1:0] iq_addr_q, iq_addr_d;
  logic            iq_jump_q, iq_jump_d;
  logic [XLEN-1:0] iq_pred_q, iq_pred_d;

  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] dec_next;
  logic            dec_jump;
  logic            dec_is_jalr;
  logic            accept;

  // Request is suppressed during a flush so the redirect cycle never consumes a word.
  assign fet_icache_req  = rdy & (state_q == S_FETCH) & ~iq_full & ~rob_flush;
  assign fet_icache_addr = pc_q;
  assign fet_inst_addr   = pc_q;
  assign accept          = fet_icache_req & icache_ready;

  // Registered push; valid is gated while frozen so the IQ sees each entry exactly once.
  assign fet_iq_valid     = iq_valid_q & rdy;
  assign fet_iq_inst      = iq_inst_q;
  assign fet_iq_addr      = iq_addr_q;
  assign fet_iq_pred_jump = iq_jump_q;
  assign fet_iq_pred_addr = iq_pred_q;

  assign opcode   = icache_inst[6:0];
  assign imm_j    = {{(XLEN-21){icache_inst[31]}}, icache_inst[31], icache_inst[19:12],
                     icache_inst[20], icache_inst[30:21], 1'b0};
  assign imm_b    = {{(XLEN-13){icache_inst[31]}}, icache_inst[31], icache_inst[7],
                     icache_inst[30:25], icache_inst[11:8], 1'b0};
  assign pc_plus4 = pc_q + XLEN'(4);

  // Control-flow decode of the returned word; bp_pred already refers to pc via fet_inst_addr.
  always_comb begin
    dec_next    = pc_plus4;
    dec_jump    = 1'b0;
    dec_is_jalr = 1'b0;
    unique case (opcode)
      OP_JAL: begin
        dec_next = pc_q + imm_j;
        dec_jump = 1'b1;
      end
      OP_BR: begin
        if (bp_pred) begin
          dec_next = pc_q + imm_b;
          dec_jump = 1'b1;
        end
      end
      OP_JALR: begin
        dec_is_jalr = 1'b1;
      end
      default: begin
        dec_next = pc_plus4;
      end
    endcase
  end

  // Next-state: flush dominates, then accept; everything holds while rdy is low.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iq_valid_d = iq_valid_q;
    iq_inst_d  = iq_inst_q;
    iq_addr_d  = iq_addr_q;
    iq_jump_d  = iq_jump_q;
    iq_pred_d  = iq_pred_q;
    if (rdy) begin
      if (rob_flush) begin
        pc_d       = rob_flush_pc;
        state_d    = S_FETCH;
        iq_valid_d = 1'b0;
      end else if (accept) begin
        pc_d       = dec_next;
        iq_valid_d = 1'b1;
        iq_inst_d  = icache_inst;
        iq_addr_d  = pc_q;
        iq_jump_d  = dec_jump;
        iq_pred_d  = dec_next;
        if (dec_is_jalr) begin
          state_d = S_WAIT_JALR;
        end
      end else begin
        iq_valid_d = 1'b0;
      end
    end
  end

  // State and push registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      iq_valid_q <= 1'b0;
      iq_inst_q  <= '0;
      iq_addr_q  <= '0;
      iq_jump_q  <= 1'b0;
      iq_pred_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iq_valid_q <= iq_valid_d;
      iq_inst_q  <= iq_inst_d;
      iq_addr_q  <= iq_addr_d;
      iq_jump_q  <= iq_jump_d;
      iq_pred_q  <= iq_pred_d;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - directed and randomized check of fetcher against a behavioural model
module tb_fetcher;

  localparam int K_OTHER = 0;
  localparam int K_JAL   = 1;
  localparam int K_BR    = 2;
  localparam int K_JALR  = 3;
  localparam int K_ILL   = 4;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        fet_icache_req;
  logic [31:0] fet_icache_addr;
  logic        icache_ready;
  logic [31:0] icache_inst;
  logic [31:0] fet_inst_addr;
  logic        bp_pred;
  logic        iq_full;
  logic        fet_iq_valid;
  logic [31:0] fet_iq_inst;
  logic [31:0] fet_iq_addr;
  logic        fet_iq_pred_jump;
  logic [31:0] fet_iq_pred_addr;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;

  fetcher #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .fet_icache_req   (fet_icache_req),
    .fet_icache_addr  (fet_icache_addr),
    .icache_ready     (icache_ready),
    .icache_inst      (icache_inst),
    .fet_inst_addr    (fet_inst_addr),
    .bp_pred          (bp_pred),
    .iq_full          (iq_full),
    .fet_iq_valid     (fet_iq_valid),
    .fet_iq_inst      (fet_iq_inst),
    .fet_iq_addr      (fet_iq_addr),
    .fet_iq_pred_jump (fet_iq_pred_jump),
    .fet_iq_pred_addr (fet_iq_pred_addr),
    .rob_flush        (rob_flush),
    .rob_flush_pc     (rob_flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: architectural PC, whether we are parked behind a JALR, and the pending push.
  logic [31:0] m_pc;
  bit          m_wait;
  bit          m_v;
  logic [31:0] m_inst, m_addr, m_pred;
  bit          m_jump;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_wait = 0; m_v = 0;
    m_inst = '0; m_addr = '0; m_pred = '0; m_jump = 0;
  endtask

  // One clock: drive, check outputs at negedge, advance the model, return just after posedge.
  task automatic step(input bit r, input bit rd, input int kind, input int off, input bit bp,
                      input bit full, input bit fl, input logic [31:0] fpc);
    logic [31:0] inst, rnd, nxt;
    bit exp_req, jmp;
    rnd = $urandom;
    case (kind)
      K_JAL:   inst = enc_jal(32'(off));
      K_BR:    inst = enc_br(32'(off));
      K_JALR:  inst = {rnd[31:7], 7'b1100111};
      K_ILL:   inst = {rnd[31:7], 7'b1111111};
      default: inst = {rnd[31:7], 7'b0010011};
    endcase
    rdy = r; icache_ready = rd; icache_inst = inst; bp_pred = bp;
    iq_full = full; rob_flush = fl; rob_flush_pc = fpc;
    @(negedge clk);
    exp_req = r && !m_wait && !full && !fl;
    check_eq("req", 32'(fet_icache_req), 32'(exp_req));
    check_eq("icache_addr", fet_icache_addr, m_pc);
    check_eq("inst_addr", fet_inst_addr, m_pc);
    check_eq("iq_valid", 32'(fet_iq_valid), 32'(r && m_v));
    if (r && m_v) begin
      check_eq("iq_inst", fet_iq_inst, m_inst);
      check_eq("iq_addr", fet_iq_addr, m_addr);
      check_eq("iq_jump", 32'(fet_iq_pred_jump), 32'(m_jump));
      check_eq("iq_pred", fet_iq_pred_addr, m_pred);
    end
    if (r) begin
      if (fl) begin
        m_pc = fpc; m_wait = 0; m_v = 0;
      end else if (exp_req && rd) begin
        jmp = (kind == K_JAL) || (kind == K_BR && bp);
        nxt = jmp ? m_pc + 32'(off) : m_pc + 32'd4;
        m_v = 1; m_inst = inst; m_addr = m_pc; m_jump = jmp; m_pred = nxt;
        m_pc = nxt;
        if (kind == K_JALR) m_wait = 1;
      end else begin
        m_v = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic addi(input int n);
    for (int i = 0; i < n; i++) step(1, 1, K_OTHER, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic flush_to(input logic [31:0] a);
    step(1, 0, K_OTHER, 0, 0, 0, 1, a);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1; rdy = 1; icache_ready = 0; icache_inst = '0; bp_pred = 0;
    iq_full = 0; rob_flush = 0; rob_flush_pc = '0;
    model_reset();
    @(negedge clk);
    check_eq("rst_valid", 32'(fet_iq_valid), 32'd0);
    check_eq("rst_inst", fet_iq_inst, 32'd0);
    check_eq("rst_addr", fet_iq_addr, 32'd0);
    check_eq("rst_jump", 32'(fet_iq_pred_jump), 32'd0);
    check_eq("rst_pred", fet_iq_pred_addr, 32'd0);
    check_eq("rst_pc", fet_icache_addr, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Sequential ADDIs from reset, then a taken and a not-taken BEQ at 0x10.
    addi(4);
    step(1, 1, K_BR, -8, 1, 0, 0, 32'h0);
    addi(1);
    flush_to(32'h10);
    step(1, 1, K_BR, -8, 0, 0, 0, 32'h0);
    addi(1);
    // JAL +0x100 at 0x20.
    flush_to(32'h20);
    step(1, 1, K_JAL, 32'h100, 0, 0, 0, 32'h0);
    addi(1);
    // JALR at 0x30 parks fetch until a flush.
    flush_to(32'h30);
    step(1, 1, K_JALR, 0, 0, 0, 0, 32'h0);
    addi(5);
    flush_to(32'h200);
    addi(2);
    // IQ backpressure holds the PC.
    for (int i = 0; i < 3; i++) step(1, 1, K_OTHER, 0, 0, 1, 0, 32'h0);
    addi(2);
    // Flush colliding with icache_ready drops the word.
    flush_to(32'h40);
    step(1, 1, K_OTHER, 0, 0, 0, 1, 32'h80);
    addi(2);
    // PC wraps modulo 2^32.
    flush_to(32'hFFFF_FFFC);
    addi(2);
    // Frozen cycles ignore ready and flush; a pending push reappears once rdy returns.
    step(1, 1, K_ILL, 0, 0, 0, 0, 32'h0);
    step(0, 1, K_OTHER, 0, 0, 0, 1, 32'h500);
    step(0, 1, K_OTHER, 0, 0, 0, 0, 32'h0);
    addi(2);

    // Asynchronous reset while parked behind a JALR with a push pending.
    step(1, 1, K_JALR, 0, 0, 0, 0, 32'h0);
    rst = 1;
    #2;
    check_eq("arst_valid", 32'(fet_iq_valid), 32'd0);
    check_eq("arst_req", 32'(fet_icache_req), 32'd1);
    check_eq("arst_pc", fet_icache_addr, 32'd0);
    rst = 0;
    model_reset();
    addi(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int kind, off, sel;
      logic [31:0] fpc;
      kind = int'($urandom_range(0, 4));
      if (kind == K_JALR && $urandom_range(0, 2) != 0) kind = K_OTHER;
      off = 0;
      if (kind == K_JAL) off = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      if (kind == K_BR)  off = (int'($urandom_range(0, 4095)) - 2048) * 2;
      sel = int'($urandom_range(0, 7));
      fpc = (sel == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, kind, off,
           1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, fpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
